wishbone_arbiter: RTL and testbench

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

---
 rtl/wishbone_arbiter.sv | 136 +++++++++++++
 tb/tb_wishbone_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter with shared slave bus, per-grant wait timeout and error pulse.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (m0 wins).
module wishbone_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, RELEASE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req0;
  logic             w_req1;
  logic             w_pick1;
  logic             w_g0;
  logic             w_g1;
  logic             w_cyc;
  logic             w_stb;
  logic             w_timeout;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_g0   = (r_state == GNT0);
  assign w_g1   = (r_state == GNT1);

`ifdef WB_ARB_ROUND_ROBIN_EN
  // r_last_m1 = 1 means m1 was granted last, so m0 wins the next tie
  logic r_last_m1;
  assign w_pick1 = w_req1 & (~w_req0 | ~r_last_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_m1 <= 1'b1;
    end else if (r_state == IDLE && (w_req0 | w_req1)) begin
      r_last_m1 <= w_pick1;
    end
  end
`else
  assign w_pick1 = w_req1 & ~w_req0;
`endif

  // Shared-bus mux: only the granted master is visible
  always_comb begin
    w_cyc    = 1'b0;
    w_stb    = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = 32'h0;
    s_data_o = 32'h0;
    s_sel_o  = 4'b0000;
    if (w_g0) begin
      w_cyc    = m0_cyc_i;
      w_stb    = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
    end else if (w_g1) begin
      w_cyc    = m1_cyc_i;
      w_stb    = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
    end
  end

  // An ack in the limit cycle wins over the timeout
  assign w_timeout = (w_g0 | w_g1) & w_stb & ~s_ack_i & (r_cnt == CNT_LAST);

  assign s_cyc_o   = w_cyc;
  assign s_stb_o   = w_stb;
  assign m0_ack_o  = w_g0 & s_ack_i;
  assign m1_ack_o  = w_g1 & s_ack_i;
  assign m0_err_o  = w_g0 & w_timeout;
  assign m1_err_o  = w_g1 & w_timeout;
  assign m0_data_o = w_g0 ? s_data_i : 32'h0;
  assign m1_data_o = w_g1 ? s_data_i : 32'h0;
  assign gnt_o     = {w_g1, w_g0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pick1)     r_state <= GNT1;
          else if (w_req0) r_state <= GNT0;
        end
        GNT0, GNT1: begin
          if (s_ack_i)    r_cnt <= '0;
          else if (w_stb) r_cnt <= r_cnt + CNT_W'(1);
          if (!w_cyc || w_timeout) r_state <= RELEASE;
        end
        RELEASE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed self-checking bench for wishbone_arbiter (TIMEOUT=8); tie-break expectations follow WB_ARB_ROUND_ROBIN_EN.
module tb_wishbone_arbiter;

  logic        clk, rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  wishbone_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drop_all();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    s_ack_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_all();
    m0_addr_i = 32'h0; m0_data_i = 32'h0; m0_sel_i = 4'h0;
    m1_addr_i = 32'h0; m1_data_i = 32'h0; m1_sel_i = 4'h0;
    s_data_i  = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 8'h00);
    end
    total++;
    if ({s_addr_o, s_sel_o, m0_data_o} !== 68'h0) begin
      bad++;
      $display("FAIL reset_bus got=%h exp=0", {s_addr_o, s_sel_o, m0_data_o});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_m1_read();
    @(negedge clk);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_1000; m1_sel_i = 4'hF;
    #1;
    total++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      bad++;
      $display("FAIL m1_idle_before_grant got=%b exp=000", {gnt_o, s_cyc_o});
    end
    @(negedge clk); #1;
    total++;
    if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o} !== 6'b10_1100) begin
      bad++;
      $display("FAIL m1_grant got=%b exp=101100", {gnt_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o});
    end
    total++;
    if (s_addr_o !== 32'h0000_1000) begin
      bad++;
      $display("FAIL m1_addr_mirror got=%h exp=00001000", s_addr_o);
    end
    repeat (2) @(negedge clk);
    @(negedge clk);
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({m1_ack_o, m0_ack_o, m1_err_o} !== 3'b100) begin
      bad++;
      $display("FAIL m1_ack got=%b exp=100", {m1_ack_o, m0_ack_o, m1_err_o});
    end
    total++;
    if ({m1_data_o, m0_data_o} !== {32'hDEAD_BEEF, 32'h0}) begin
      bad++;
      $display("FAIL m1_read_data got=%h exp=%h", {m1_data_o, m0_data_o}, {32'hDEAD_BEEF, 32'h0});
    end
    @(negedge clk);
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    #1;
    total++;
    if (gnt_o !== 2'b10) begin
      bad++;
      $display("FAIL m1_hold_until_edge got=%b exp=10", gnt_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    total++;
    if ({gnt_o, s_cyc_o, m1_ack_o, m1_data_o} !== 36'h0) begin
      bad++;
      $display("FAIL m1_release_ignores_ack got=%h exp=0", {gnt_o, s_cyc_o, m1_ack_o, m1_data_o});
    end
    @(negedge clk);
    s_ack_i = 1'b0;
    #1;
    total++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      bad++;
      $display("FAIL m1_back_to_idle got=%b exp=000", {gnt_o, s_cyc_o});
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m0_addr_i = 32'h0000_2000; m0_data_i = 32'h1234_5678; m0_sel_i = 4'hF;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h0000_3000;
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    total++;
    if ({gnt_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o} !== 9'b01_1_1111_10) begin
      bad++;
      $display("FAIL sim_m0_first got=%b exp=011111110", {gnt_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o});
    end
    total++;
    if ({s_addr_o, s_data_o} !== {32'h0000_2000, 32'h1234_5678}) begin
      bad++;
      $display("FAIL sim_m0_write_bus got=%h exp=%h", {s_addr_o, s_data_o}, {32'h0000_2000, 32'h1234_5678});
    end
    @(negedge clk);
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    @(negedge clk); #1;
    total++;
    if (gnt_o !== 2'b00) begin
      bad++;
      $display("FAIL sim_gap_release got=%b exp=00", gnt_o);
    end
    @(negedge clk); #1;
    total++;
    if (gnt_o !== 2'b00) begin
      bad++;
      $display("FAIL sim_gap_idle got=%b exp=00", gnt_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    total++;
    if ({gnt_o, s_we_o, m1_ack_o, m0_ack_o} !== 5'b10_0_10) begin
      bad++;
      $display("FAIL sim_m1_second got=%b exp=10010", {gnt_o, s_we_o, m1_ack_o, m0_ack_o});
    end
    total++;
    if (s_addr_o !== 32'h0000_3000) begin
      bad++;
      $display("FAIL sim_m1_addr got=%h exp=00003000", s_addr_o);
    end
    @(negedge clk);
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic ok;
    @(negedge clk);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h0000_4000;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_ack_i = 1'b1; m0_addr_i = 32'h0000_4000 + 32'(i * 4);
      #1;
      total++;
      if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b01_10) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%b exp=0110", i, {gnt_o, m0_ack_o, m1_ack_o});
      end
    end
    @(negedge clk);
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    ok = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      if (gnt_o !== 2'b00 || m1_ack_o !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_gap got=0 exp=1");
    end
    @(negedge clk); #1;
    total++;
    if (gnt_o !== 2'b10) begin
      bad++;
      $display("FAIL b2b_m1_after got=%b exp=10", gnt_o);
    end
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic exp_err;
    @(negedge clk);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      exp_err = (i == 8);
      total++;
      if ({gnt_o, m0_err_o, m0_ack_o, s_cyc_o} !== {2'b01, exp_err, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL timeout_wait%0d got=%b exp=%b", i,
                 {gnt_o, m0_err_o, m0_ack_o, s_cyc_o}, {2'b01, exp_err, 1'b0, 1'b1});
      end
    end
    @(negedge clk); #1;
    total++;
    if ({s_cyc_o, s_stb_o, gnt_o, m0_err_o, m0_ack_o} !== 6'b0) begin
      bad++;
      $display("FAIL timeout_bus_drop got=%b exp=000000", {s_cyc_o, s_stb_o, gnt_o, m0_err_o, m0_ack_o});
    end
    drop_all();
    @(negedge clk);
  endtask

  task automatic test_ack_at_timeout();
    @(negedge clk);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    repeat (7) @(negedge clk);
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    total++;
    if ({m0_ack_o, m0_err_o} !== 2'b10) begin
      bad++;
      $display("FAIL ack_wins_timeout got=%b exp=10", {m0_ack_o, m0_err_o});
    end
    @(negedge clk);
    s_ack_i = 1'b0;
    #1;
    total++;
    if ({gnt_o, s_cyc_o, m0_err_o} !== 4'b01_1_0) begin
      bad++;
      $display("FAIL ack_clears_counter got=%b exp=0110", {gnt_o, s_cyc_o, m0_err_o});
    end
    drop_all();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tie_after_m0();
    logic [1:0] exp_gnt;
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_gnt = 2'b10;
`else
    exp_gnt = 2'b01;
`endif
    @(negedge clk);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    @(negedge clk); #1;
    total++;
    if (gnt_o !== exp_gnt) begin
      bad++;
      $display("FAIL tie_winner got=%b exp=%b", gnt_o, exp_gnt);
    end
    drop_all();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_5000;
    @(negedge clk); #1;
    total++;
    if (gnt_o !== 2'b10) begin
      bad++;
      $display("FAIL rst_pre_grant got=%b exp=10", gnt_o);
    end
    @(negedge clk);
    #1;
    rst = 1'b1; s_ack_i = 1'b1;
    #1;
    total++;
    if ({s_cyc_o, gnt_o, m1_ack_o, m1_err_o, m1_data_o} !== 37'h0) begin
      bad++;
      $display("FAIL rst_mid_grant got=%h exp=0", {s_cyc_o, gnt_o, m1_ack_o, m1_err_o, m1_data_o});
    end
    @(negedge clk);
    rst = 1'b0; s_ack_i = 1'b0;
    #1;
    total++;
    if (gnt_o !== 2'b00) begin
      bad++;
      $display("FAIL rst_release_idle got=%b exp=00", gnt_o);
    end
    @(negedge clk); #1;
    total++;
    if ({gnt_o, s_cyc_o} !== 3'b101) begin
      bad++;
      $display("FAIL rst_regrant got=%b exp=101", {gnt_o, s_cyc_o});
    end
    drop_all();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_m1_read();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_tie_after_m0();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
